// File: rtl/mt_io_ctrl.sv
// Microtan 65 system I/O block: keypad column latch, graphics latch, single-step NMI
// delay and N_IRQ edge-triggered interrupt sources with status/mask registers.
module mt_io_ctrl #(
   parameter logic [15:0] BASE_ADDR = 16'hBFF0,
   parameter int          N_IRQ     = 4,
   parameter int          NMI_DELAY = 3,
   parameter int          COL_WIDTH = 5,
   parameter int          ROW_WIDTH = 7
) (
   input  logic                 cpu_clk,
   input  logic                 cpu_reset,
   input  logic                 cpu_clken,
   input  logic [15:0]          cpu_addr,
   input  logic                 cpu_we,
   input  logic [7:0]           cpu_din,
   input  logic                 cpu_sync,
   input  logic [ROW_WIDTH-1:0] key_row,
   input  logic [N_IRQ-1:0]     irq_src,
   output logic [7:0]           cpu_dout,
   output logic                 cpu_dout_en,
   output logic [COL_WIDTH-1:0] key_col,
   output logic                 graphics,
   output logic                 irq,
   output logic                 nmi,
   output logic [N_IRQ-1:0]     irq_status
);

   localparam int CNT_W = $clog2(NMI_DELAY + 1);

   logic [COL_WIDTH-1:0] r_key_col;
   logic                 r_graphics;
   logic [CNT_W-1:0]     r_nmi_cnt;
   logic [N_IRQ-1:0]     r_status;
   logic [N_IRQ-1:0]     r_mask;
   logic [N_IRQ-1:0]     r_hist;

   logic                 w_sel;
   logic [2:0]           w_off;
   logic                 w_wr;
   logic                 w_rd;
   logic [N_IRQ-1:0]     w_set;
   logic [N_IRQ-1:0]     w_clr;
   logic [7:0]           w_rdata;
   logic                 w_unused;

   // Address bit 3 is deliberately not decoded, so offsets 8-F mirror 0-7.
   assign w_sel = (cpu_addr[15:4] == BASE_ADDR[15:4]);
   assign w_off = cpu_addr[2:0];
   assign w_wr  = w_sel && cpu_we && cpu_clken;
   assign w_rd  = w_sel && !cpu_we && cpu_clken;
   assign w_set = irq_src & ~r_hist;

   always_comb begin
      w_clr = '0;
      if (w_wr && (w_off == 3'd0)) w_clr[0] = 1'b1;
      if (w_wr && (w_off == 3'd4)) w_clr = w_clr | cpu_din[N_IRQ-1:0];
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_reset) begin
         r_key_col  <= '0;
         r_graphics <= 1'b0;
         r_nmi_cnt  <= '0;
         r_status   <= '0;
         r_mask     <= N_IRQ'(1);
         r_hist     <= irq_src;
      end else if (cpu_clken) begin
         r_hist   <= irq_src;
         // Set is OR-ed in after the clear so a coincident edge is never lost.
         r_status <= (r_status & ~w_clr) | w_set;

         if (w_wr && (w_off == 3'd1))
            r_nmi_cnt <= CNT_W'(NMI_DELAY);
         else if (cpu_sync && (r_nmi_cnt != '0))
            r_nmi_cnt <= r_nmi_cnt - CNT_W'(1);

         if (w_wr && (w_off == 3'd2))
            r_key_col <= cpu_din[COL_WIDTH-1:0];

         if (w_wr && (w_off == 3'd3))
            r_graphics <= 1'b0;
         else if (w_rd && (w_off == 3'd0))
            r_graphics <= 1'b1;

         if (w_wr && (w_off == 3'd5))
            r_mask <= cpu_din[N_IRQ-1:0];
      end
   end

   // Unused high bits read back as 1.
   always_comb begin
      w_rdata = 8'hFF;
      case (w_off)
         3'd3: w_rdata[ROW_WIDTH:0] = {r_status[0], key_row};
         3'd4: w_rdata[N_IRQ-1:0]   = r_status;
         3'd5: w_rdata[N_IRQ-1:0]   = r_mask;
         3'd6: w_rdata[CNT_W-1:0]   = r_nmi_cnt;
         default: w_rdata = 8'hFF;
      endcase
   end

   assign cpu_dout    = w_rdata;
   assign cpu_dout_en = w_sel && !cpu_we;
   assign key_col     = r_key_col;
   assign graphics    = r_graphics;
   assign irq         = |(r_status & r_mask);
   assign nmi         = (r_nmi_cnt == CNT_W'(1));
   assign irq_status  = r_status;

   assign w_unused = ^{cpu_addr[3], cpu_din};

endmodule
